// File: rtl/cp0_pkg.sv
// cp0_pkg
// Shared constants and helpers for the CP0 system-control register file.
// Holds the CP0 register numbers, the committed exception codes arriving
// from the MEM stage, the Status reset value and the software-writable mask
// for Cause. Also provides a classifier that turns a raw excepttype code
// into the kind of commit event it represents.
//
// Optional build macro used by the CP0 files: CP0_COUNT_HALFRATE_EN
// (Count advances once every two cycles when defined).
package cp0_pkg;

    // CP0 register numbers as seen by MFC0/MTC0
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    // Committed exception codes; zero means no commit this cycle
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    // Status comes out of reset with BEV set
    localparam logic [31:0] STATUS_RST = 32'h0040_0000;

    // Cause bits software may change: IV(23), WP(22), IP[9:8]
    localparam logic [31:0] CAUSE_SW_MASK = 32'h00C0_0300;

    // Kind of commit event carried by excepttype
    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXC,
        EV_ERET
    } cp0_event_e;

    // Unknown codes fall into EV_NONE so they are silently ignored
    function automatic cp0_event_e classify_exc(input logic [31:0] code);
        cp0_event_e ev;
        case (code)
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
            EXC_RI, EXC_OV, EXC_TRAP: ev = EV_EXC;
            EXC_ERET:                 ev = EV_ERET;
            default:                  ev = EV_NONE;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer
// Count/Compare timer of the CP0 register file.
// Count free-runs (wrapping at 2^32); a Compare match with a non-zero
// Compare raises a sticky timer interrupt that only a Compare write clears.
// With CP0_COUNT_HALFRATE_EN defined, a toggle flop lets Count advance only
// every second cycle.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   count_we_i     MTC0 write strobe for Count
//   compare_we_i   MTC0 write strobe for Compare
//   wdata_i        MTC0 write data
//   count_o        current Count
//   compare_o      current Compare
//   timer_int_o    registered timer interrupt request
module cp0_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_int_q, timer_int_d;

`ifdef CP0_COUNT_HALFRATE_EN
    logic        tog_q, tog_d;

    // Count only advances on cycles where the toggle is high; an MTC0 to
    // Count reloads it and restarts the half-rate phase.
    always_comb begin
        tog_d   = ~tog_q;
        count_d = tog_q ? count_q + 32'd1 : count_q;
        if (count_we_i) begin
            count_d = wdata_i;
            tog_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_q <= 1'b0;
        end else begin
            tog_q <= tog_d;
        end
    end
`else
    // Count advances every cycle unless software is loading it
    always_comb begin
        count_d = count_q + 32'd1;
        if (count_we_i) begin
            count_d = wdata_i;
        end
    end
`endif

    // The interrupt latches on a match of the current register values and
    // holds until software rewrites Compare; a Compare write always wins.
    always_comb begin
        compare_d   = compare_we_i ? wdata_i : compare_q;
        timer_int_d = timer_int_q;
        if ((compare_q != 32'd0) && (count_q == compare_q)) begin
            timer_int_d = 1'b1;
        end
        if (compare_we_i) begin
            timer_int_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_reg.sv
// cp0_reg
// CP0 system-control register file for the 5-stage MIPS pipeline.
// Serves the combinational MFC0 read port from EX, commits MTC0 writes from
// WB, and applies precise-exception / ERET commits from MEM. The
// Count/Compare timer lives in cp0_timer.
// Optional build macro: CP0_COUNT_HALFRATE_EN (half-rate Count, in cp0_timer).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   we_i, waddr_i, wdata_i  MTC0 write port
//   raddr_i, rdata_o        MFC0 read port (combinational, no write bypass)
//   int_i                   level-sensitive hardware interrupt lines
//   excepttype_i            committed exception code (0 = none, 0xe = ERET)
//   current_inst_addr_i     PC of the excepting instruction
//   is_in_delayslot_i       excepting instruction is in a delay slot
//   badvaddr_i              faulting address for AdEL/AdES
//   count_o .. epc_o        live register values
//   timer_int_o             timer interrupt request
module cp0_reg
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] badvaddr_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_w, compare_w;
    logic        timer_int_w;
    logic        count_we, compare_we;
    cp0_event_e  ev;

    assign count_we   = we_i && (waddr_i == CP0_COUNT);
    assign compare_we = we_i && (waddr_i == CP0_COMPARE);
    assign ev         = classify_exc(excepttype_i);

    cp0_timer u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_we_i   (count_we),
        .compare_we_i (compare_we),
        .wdata_i      (wdata_i),
        .count_o      (count_w),
        .compare_o    (compare_w),
        .timer_int_o  (timer_int_w)
    );

    // Next-state for Status/Cause/EPC/BadVAddr. The MTC0 is applied first
    // and the exception commit layered on top, so the exception wins on
    // EXL, ExcCode, BD and EPC. The EXL test sees the post-MTC0 Status.
    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (we_i) begin
            case (waddr_i)
                CP0_STATUS: status_d = wdata_i;
                CP0_CAUSE:  cause_d  = (cause_q & ~CAUSE_SW_MASK) | (wdata_i & CAUSE_SW_MASK);
                CP0_EPC:    epc_d    = wdata_i;
                default:    ;
            endcase
        end

        // Hardware IP bits track the pins; IP7 also carries the timer
        cause_d[15:10] = {int_i[5] | timer_int_w, int_i[4:0]};

        case (ev)
            EV_EXC: begin
                if (!status_d[1]) begin
                    epc_d      = is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                                   : current_inst_addr_i;
                    cause_d[31] = is_in_delayslot_i;
                end
                status_d[1]  = 1'b1;
                cause_d[6:2] = excepttype_i[4:0];
                if ((excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES)) begin
                    badvaddr_d = badvaddr_i;
                end
            end
            EV_ERET: status_d[1] = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // MFC0 read mux; EX forwards in-flight MTC0 data itself
    always_comb begin
        rdata_o = 32'd0;
        case (raddr_i)
            CP0_BADVADDR: rdata_o = badvaddr_q;
            CP0_COUNT:    rdata_o = count_w;
            CP0_COMPARE:  rdata_o = compare_w;
            CP0_STATUS:   rdata_o = status_q;
            CP0_CAUSE:    rdata_o = cause_q;
            CP0_EPC:      rdata_o = epc_q;
            CP0_PRID:     rdata_o = PRID_VAL;
            CP0_CONFIG:   rdata_o = CONFIG_VAL;
            default:      rdata_o = 32'd0;
        endcase
    end

    assign count_o     = count_w;
    assign compare_o   = compare_w;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign timer_int_o = timer_int_w;

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg
// Self-checking bench for cp0_reg: directed scenarios followed by a random
// run, all compared against a behavioural model of the CP0 register rules.
// Honours CP0_COUNT_HALFRATE_EN for the Count rate.
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = 5'd0;
    logic [31:0] wdata = 32'd0;
    logic [4:0]  raddr = 5'd0;
    logic [31:0] rdata;
    logic [5:0]  intLines = 6'd0;
    logic [31:0] excType = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        delaySlot = 1'b0;
    logic [31:0] badAddr = 32'd0;
    logic [31:0] countO, compareO, statusO, causeO, epcO;
    logic        timerO;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] mCount, mCompare, mStatus, mCause, mEpc, mBadv;
    logic        mTimer;
    bit          mHalf;

    localparam logic [31:0] SW_MASK = 32'h00C0_0300;

    cp0_reg dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .we_i                (we),
        .waddr_i             (waddr),
        .wdata_i             (wdata),
        .raddr_i             (raddr),
        .rdata_o             (rdata),
        .int_i               (intLines),
        .excepttype_i        (excType),
        .current_inst_addr_i (pc),
        .is_in_delayslot_i   (delaySlot),
        .badvaddr_i          (badAddr),
        .count_o             (countO),
        .compare_o           (compareO),
        .status_o            (statusO),
        .cause_o             (causeO),
        .epc_o               (epcO),
        .timer_int_o         (timerO)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mCount = 0; mCompare = 0; mStatus = 32'h0040_0000;
        mCause = 0; mEpc = 0; mBadv = 0; mTimer = 0; mHalf = 0;
    endtask

    // One clock of CP0 behaviour, computed from the register rules
    task automatic modelStep();
        logic [31:0] nCount, nCompare, nStatus, nCause, nEpc, nBadv;
        logic        nTimer;
        bit          nHalf;
        bit          isExc;
`ifdef CP0_COUNT_HALFRATE_EN
        nCount = mHalf ? mCount + 1 : mCount;
        nHalf  = !mHalf;
`else
        nCount = mCount + 1;
        nHalf  = 0;
`endif
        nCompare = mCompare;
        nTimer   = mTimer || (mCompare != 0 && mCount == mCompare);
        nStatus  = mStatus;
        nCause   = mCause;
        nEpc     = mEpc;
        nBadv    = mBadv;
        if (we) begin
            if (waddr == 9)  begin nCount = wdata; nHalf = 0; end
            if (waddr == 11) begin nCompare = wdata; nTimer = 0; end
            if (waddr == 12) nStatus = wdata;
            if (waddr == 13) nCause = (mCause & ~SW_MASK) | (wdata & SW_MASK);
            if (waddr == 14) nEpc = wdata;
        end
        nCause[15] = intLines[5] | mTimer;
        nCause[14:10] = intLines[4:0];
        isExc = excType inside {32'h1, 32'h4, 32'h5, 32'h8, 32'ha, 32'hc, 32'hd};
        if (isExc) begin
            if (nStatus[1] == 0) begin
                nEpc = delaySlot ? pc - 4 : pc;
                nCause[31] = delaySlot;
            end
            nStatus[1] = 1;
            nCause[6:2] = excType[4:0];
            if (excType == 4 || excType == 5) nBadv = badAddr;
        end else if (excType == 32'he) begin
            nStatus[1] = 0;
        end
        mCount = nCount; mCompare = nCompare; mTimer = nTimer; mStatus = nStatus;
        mCause = nCause; mEpc = nEpc; mBadv = nBadv; mHalf = nHalf;
    endtask

    function automatic logic [31:0] mRead(input logic [4:0] a);
        case (a)
            5'd8:  return mBadv;
            5'd9:  return mCount;
            5'd11: return mCompare;
            5'd12: return mStatus;
            5'd13: return mCause;
            5'd14: return mEpc;
            5'd15: return 32'h0001_8000;
            5'd16: return 32'h0000_8000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".count"},   countO,   mCount);
        checkOutput({tag, ".compare"}, compareO, mCompare);
        checkOutput({tag, ".status"},  statusO,  mStatus);
        checkOutput({tag, ".cause"},   causeO,   mCause);
        checkOutput({tag, ".epc"},     epcO,     mEpc);
        checkOutput({tag, ".timer"},   {31'd0, timerO}, {31'd0, mTimer});
        checkOutput({tag, ".rdata"},   rdata,    mRead(raddr));
    endtask

    // Advance one clock with the currently driven inputs, then compare
    task automatic applyStimulus(input string tag);
        @(posedge clk);
        modelStep();
        #1;
        checkState(tag);
    endtask

    task automatic idleInputs();
        we = 0; waddr = 0; wdata = 0; excType = 0; pc = 0;
        delaySlot = 0; badAddr = 0; intLines = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input string tag);
        we = 1; waddr = a; wdata = d;
        applyStimulus(tag);
        we = 0;
    endtask

    initial begin
        logic [31:0] prevCause;
        int budget;
        modelReset();
        idleInputs();
        raddr = 5'd15;
        repeat (3) @(posedge clk);
        #1;
        checkState("reset");
        checkOutput("reset.status", statusO, 32'h0040_0000);
        @(negedge clk);
        rst_n = 1;

        // Free run after reset
        for (int i = 0; i < 10; i++) applyStimulus("freerun");
`ifdef CP0_COUNT_HALFRATE_EN
        checkOutput("count10", countO, 32'd5);
`else
        checkOutput("count10", countO, 32'd10);
`endif
        checkOutput("status10", statusO, 32'h0040_0000);
        checkOutput("prid", rdata, 32'h0001_8000);

        // Timer match
        raddr = 5'd11;
        mtc0(5'd11, 32'd20, "wrCompare");
        mtc0(5'd9, 32'd5, "wrCount");
        budget = 0;
        while (mCount != 32'd20 && budget < 100) begin
            applyStimulus("timerwait");
            budget++;
        end
        checkOutput("timerwait.budget", {31'd0, budget < 100}, 32'd1);
        checkOutput("timer.pre", {31'd0, timerO}, 32'd0);
        applyStimulus("timer.edge");
        checkOutput("timer.rise", {31'd0, timerO}, 32'd1);
        applyStimulus("timer.ip");
        checkOutput("timer.cause15", {31'd0, causeO[15]}, 32'd1);
        mtc0(5'd11, 32'd100, "wrCompare100");
        checkOutput("timer.clear", {31'd0, timerO}, 32'd0);
        mtc0(5'd11, 32'd0, "wrCompare0");

        // Exception in delay slot, nested exception, ERET
        raddr = 5'd14;
        excType = 32'h8; pc = 32'h100; delaySlot = 1;
        applyStimulus("syscall");
        checkOutput("syscall.epc", epcO, 32'h0000_00FC);
        checkOutput("syscall.bd", {31'd0, causeO[31]}, 32'd1);
        checkOutput("syscall.code", {27'd0, causeO[6:2]}, 32'd8);
        checkOutput("syscall.exl", {31'd0, statusO[1]}, 32'd1);
        excType = 32'hc; pc = 32'h200; delaySlot = 0;
        applyStimulus("nestedOv");
        checkOutput("nested.epc", epcO, 32'h0000_00FC);
        checkOutput("nested.code", {27'd0, causeO[6:2]}, 32'hc);
        excType = 32'he; pc = 32'h0;
        applyStimulus("eret");
        checkOutput("eret.exl", {31'd0, statusO[1]}, 32'd0);
        checkOutput("eret.epc", epcO, 32'h0000_00FC);

        // AdEL captures the faulting address
        raddr = 5'd8;
        excType = 32'h4; pc = 32'h300; badAddr = 32'hDEAD_BEE1;
        applyStimulus("adel");
        checkOutput("adel.badv", rdata, 32'hDEAD_BEE1);
        excType = 32'he;
        applyStimulus("eret2");
        excType = 32'h0;

        // MTC0 Status and interrupt exception in the same cycle
        we = 1; waddr = 5'd12; wdata = 32'h0; excType = 32'h1; pc = 32'h400;
        applyStimulus("sameCycle");
        idleInputs();
        checkOutput("sameCycle.status", statusO, 32'h0000_0002);
        checkOutput("sameCycle.epc", epcO, 32'h0000_0400);

        // Cause software write only touches IV, WP and IP[9:8]
        prevCause = mCause;
        mtc0(5'd13, 32'hFFFF_FFFF, "wrCause");
        checkOutput("cause.swbits", causeO & SW_MASK, SW_MASK);
        checkOutput("cause.others", causeO & ~SW_MASK & ~32'h0000_FC00,
                    prevCause & ~SW_MASK & ~32'h0000_FC00);

        // Writes to read-only / unmapped registers are ignored
        raddr = 5'd15;
        mtc0(5'd15, 32'h1234_5678, "wrPrid");
        checkOutput("prid.ro", rdata, 32'h0001_8000);
        raddr = 5'd3;
        mtc0(5'd3, 32'h1234_5678, "wrUnmapped");
        checkOutput("unmapped.read", rdata, 32'd0);

        // Count wrap
        raddr = 5'd9;
        mtc0(5'd9, 32'hFFFF_FFFF, "wrCountMax");
        applyStimulus("wrap1");
        applyStimulus("wrap2");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 2) == 0);
            waddr = $urandom_range(0, 1) ? 5'($urandom_range(8, 16)) : 5'($urandom_range(0, 31));
            wdata = $urandom;
            if (waddr == 5'd11 && $urandom_range(0, 1) == 1) wdata = mCount + 32'($urandom_range(0, 6));
            raddr = 5'($urandom_range(0, 31));
            intLines = 6'($urandom);
            case ($urandom_range(0, 15))
                0: excType = 32'h1;
                1: excType = 32'h4;
                2: excType = 32'h5;
                3: excType = 32'h8;
                4: excType = 32'ha;
                5: excType = 32'hc;
                6: excType = 32'hd;
                7: excType = 32'he;
                8: excType = 32'h3;
                9: excType = 32'($urandom);
                default: excType = 32'h0;
            endcase
            pc = $urandom;
            delaySlot = 1'($urandom);
            badAddr = $urandom;
            applyStimulus("random");
        end

        // Asynchronous reset mid-operation, observed with no clock edge
        idleInputs();
        raddr = 5'd8;
        #2;
        rst_n = 0;
        #1;
        modelReset();
        checkState("asyncReset");
        checkOutput("asyncReset.count", countO, 32'd0);
        checkOutput("asyncReset.timer", {31'd0, timerO}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) applyStimulus("postReset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- System-control coprocessor (CP0) register file of the 5-stage MIPS pipeline.
- Answers the MFC0 read port driven from EX (combinational read address in, data out).
- Commits MTC0 writes arriving from the WB stage.
- Takes precise-exception and ERET commits from the MEM-stage exception logic.
- Owns the Count/Compare timer and the interrupt-pending state.

Parameters:
- PRID_VAL, 32'h0001_8000, read-only contents of PRId (reg 15).
- CONFIG_VAL, 32'h0000_8000, read-only contents of Config (reg 16).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we_i  in  1  MTC0 write enable (from WB).
- waddr_i  in  5  MTC0 destination register number.
- wdata_i  in  32  MTC0 write data.
- raddr_i  in  5  MFC0 read address (from EX).
- rdata_o  out  32  MFC0 read data, combinational.
- int_i  in  6  external hardware interrupt lines, level-sensitive.
- excepttype_i  in  32  committed exception code from MEM; 0 means none.
- current_inst_addr_i  in  32  PC of the excepting instruction.
- is_in_delayslot_i  in  1  excepting instruction sits in a delay slot.
- badvaddr_i  in  32  faulting address for AdEL/AdES.
- count_o, compare_o, status_o, cause_o, epc_o  out  32 each  live register values.
- timer_int_o  out  1  timer interrupt request.

Behaviour:
- Register map: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16.
- Unmapped read addresses return 0. Writes to unmapped addresses are ignored.
- Reset values:
  - Status = 32'h0040_0000 (BEV=1).
  - Count, Compare, Cause, EPC, BadVAddr = 0.
  - timer_int_o = 0.
  - All outputs follow the reset values immediately on the asynchronous assert.
- Reads:
  - Pure mux on raddr_i.
  - A same-cycle write is not bypassed; EX forwards from MEM/WB itself.
- Count:
  - Increments by 1 every cycle.
  - Wraps 32'hFFFF_FFFF -> 0.
  - An MTC0 to Count loads wdata_i and suppresses that cycle's increment.
- Timer:
  - timer_int_o sets (registered) when Compare != 0 and Count == Compare.
  - It stays set until an MTC0 to Compare, which clears it on the same edge.
- Cause.IP:
  - Cause[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]} every cycle.
  - MTC0 to Cause writes only IP[9:8] (bits 9:8), IV (bit 23) and WP (bit 22). All other bits are unchanged by software writes.
- Status and EPC are fully writable. BadVAddr, PRId and Config are read-only.
- Exception commit (excepttype_i in {0x1 int, 0x4 AdEL, 0x5 AdES, 0x8 syscall, 0xa RI, 0xc Ov, 0xd trap}):
  - If Status.EXL == 0:
    - EPC <= is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i.
    - Cause.BD(31) <= is_in_delayslot_i.
  - If Status.EXL == 1, EPC and BD are left unchanged.
  - Always: Status.EXL(1) <= 1 and Cause.ExcCode(6:2) <= the code.
  - For AdEL/AdES, BadVAddr <= badvaddr_i.
- ERET (excepttype_i == 0xe): Status.EXL <= 0. Nothing else changes.
- Unknown non-zero excepttype_i values are ignored.
- Simultaneous MTC0 and exception in the same cycle: apply the MTC0 first, then the exception. The exception wins on overlapping fields (EXL, ExcCode, BD, EPC).
- Reset mid-operation: all state returns to the reset values, including a pending timer_int_o.

Optional Feature:
- Macro: CP0_COUNT_HALFRATE_EN.
- Defined:
  - A toggle flop (reset 0) gates Count so it increments only on cycles where the toggle is 1, i.e. once every 2 cycles.
  - An MTC0 to Count also clears the toggle.
- Undefined: Count increments every cycle and no toggle flop exists.

Decomposition:
- cp0_pkg holds:
  - Register-number constants (CP0_BADVADDR ... CP0_CONFIG).
  - Exception-code constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_RI, EXC_OV, EXC_TRAP, EXC_ERET).
  - STATUS_RST and the Cause software-write mask 32'h00C0_0300.
- Sub-module cp0_timer holds Count, Compare, timer_int_o and the half-rate toggle. It takes the write strobes for Count and Compare from cp0_reg.

Test Plan:
- Reset then release, 10 cycles, no writes -> count_o == 10, status_o == 32'h0040_0000, rdata_o(raddr=15) == 32'h0001_8000.
- MTC0 Compare=20, Count=5 -> timer_int_o rises exactly at the edge after Count==20 and cause_o[15] == 1. MTC0 Compare=100 -> timer_int_o == 0 on the next cycle.
- excepttype_i=0x8, PC=0x100, delayslot=1, EXL=0 -> epc_o == 0xFC, cause_o[31] == 1, cause_o[6:2] == 8, status_o[1] == 1. A following excepttype_i=0xe -> status_o[1] == 0, epc_o still 0xFC.
- Second exception 0xc at PC=0x200 while EXL=1 -> epc_o remains 0xFC, ExcCode == 0xc.
- Same cycle: MTC0 Status=0 plus exception 0x1 -> status_o == 32'h0000_0002. MTC0 Cause=32'hFFFF_FFFF -> only bits 23, 22, 9:8 become set.
- With CP0_COUNT_HALFRATE_EN: 10 cycles after reset -> count_o == 5. Assert rst_n=0 mid-count -> count_o == 0 with no clock edge.
